// File: rtl/alert_sender.sv
// Transmitter side of the differential alert protocol: turns alert requests and pings into
// a four-phase handshake on alert_p/alert_n. Optional fatal mode via ALERT_SENDER_FATAL_EN.
module alert_sender #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PAUSE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       alert_req_i,
    output logic       alert_ack_o,
    output logic       ping_ok_o,
    output logic       integ_fail_o,
    input  logic       ping_p_i,
    input  logic       ping_n_i,
    input  logic       ack_p_i,
    input  logic       ack_n_i,
    output logic       alert_p_o,
    output logic       alert_n_o,
    output logic [1:0] state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH1   = 2'd1,
        PH2   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    localparam logic [3:0] PAUSE_LAST = 4'(PAUSE_CYCLES - 1);

    logic ping_p_s, ping_n_s, ack_p_s, ack_n_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ping_p_s = ping_p_i;
            assign ping_n_s = ping_n_i;
            assign ack_p_s  = ack_p_i;
            assign ack_n_s  = ack_n_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] ping_p_q, ping_n_q, ack_p_q, ack_n_q;

            // Flops reset to the idle encoding so the pairs decode as valid out of reset.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ping_p_q <= '0;
                    ping_n_q <= '1;
                    ack_p_q  <= '0;
                    ack_n_q  <= '1;
                end else begin
                    ping_p_q <= {ping_p_q[SYNC_STAGES-2:0], ping_p_i};
                    ping_n_q <= {ping_n_q[SYNC_STAGES-2:0], ping_n_i};
                    ack_p_q  <= {ack_p_q[SYNC_STAGES-2:0], ack_p_i};
                    ack_n_q  <= {ack_n_q[SYNC_STAGES-2:0], ack_n_i};
                end
            end

            assign ping_p_s = ping_p_q[SYNC_STAGES-1];
            assign ping_n_s = ping_n_q[SYNC_STAGES-1];
            assign ack_p_s  = ack_p_q[SYNC_STAGES-1];
            assign ack_n_s  = ack_n_q[SYNC_STAGES-1];
        end
    endgenerate

    logic ping_valid, ack_valid, ack_on, integ_fail, ping_event;
    logic ping_lvl_q;

    assign ping_valid   = ping_p_s ^ ping_n_s;
    assign ack_valid    = ack_p_s ^ ack_n_s;
    assign ack_on       = ack_valid & ack_p_s;
    assign integ_fail   = ~ping_valid | ~ack_valid;
    assign ping_event   = ping_valid & (ping_p_s != ping_lvl_q);
    assign integ_fail_o = integ_fail;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       alert_pend_q, ping_pend_q, is_alert_q;
    logic       start, done, start_alert, start_ping, done_alert, done_ping;
    logic       fatal_q;

`ifdef ALERT_SENDER_FATAL_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fatal_q <= 1'b0;
        end else if (start_alert) begin
            fatal_q <= 1'b1;
        end
    end
`else
    assign fatal_q = 1'b0;
`endif

    // A fault on either pair freezes the FSM; nothing advances until both pairs are valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        done    = 1'b0;
        if (!integ_fail) begin
            case (state_q)
                IDLE: begin
                    if (alert_pend_q || alert_req_i || ping_pend_q || ping_event) begin
                        state_d = PH1;
                        start   = 1'b1;
                    end
                end
                PH1: begin
                    if (ack_on) begin
                        state_d = PH2;
                    end
                end
                PH2: begin
                    if (!ack_on) begin
                        state_d = PAUSE;
                        done    = 1'b1;
                        cnt_d   = 4'd0;
                    end
                end
                PAUSE: begin
                    if (cnt_q == PAUSE_LAST) begin
                        if (fatal_q) begin
                            state_d = PH1;
                            start   = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign start_alert = start & (alert_pend_q | alert_req_i | fatal_q);
    assign start_ping  = start & ~start_alert;
    assign done_alert  = done & is_alert_q;
    assign done_ping   = done & ~is_alert_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                is_alert_q <= start_alert;
            end
        end
    end

    // Requests still register during a fault so none are lost; they are serviced afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alert_pend_q <= 1'b0;
            ping_pend_q  <= 1'b0;
            ping_lvl_q   <= 1'b0;
        end else begin
            if (start_alert) begin
                alert_pend_q <= 1'b0;
            end else if (alert_req_i) begin
                alert_pend_q <= 1'b1;
            end
            // A completed alert also answers any outstanding ping.
            ping_pend_q <= (ping_pend_q & ~(start_ping | done_alert | fatal_q))
                         | (ping_event & ~start_ping & ~fatal_q);
            if (ping_valid) begin
                ping_lvl_q <= ping_p_s;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alert_p_o   <= 1'b0;
            alert_n_o   <= 1'b1;
            alert_ack_o <= 1'b0;
            ping_ok_o   <= 1'b0;
        end else begin
            alert_p_o   <= integ_fail | (state_d == PH1);
            alert_n_o   <= integ_fail | (state_d != PH1);
            alert_ack_o <= done_alert;
            ping_ok_o   <= done_ping;
        end
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alert_sender.sv
// Directed bench for alert_sender (default parameters, fatal mode disabled).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alert_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       alert_req;
    logic       alert_ack;
    logic       ping_ok;
    logic       integ_fail;
    logic       ping_p, ping_n, ack_p, ack_n;
    logic       alert_p, alert_n;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int n_alert_ack = 0;
    int n_ping_ok = 0;
    int base;

    alert_sender dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alert_req_i (alert_req),
        .alert_ack_o (alert_ack),
        .ping_ok_o   (ping_ok),
        .integ_fail_o(integ_fail),
        .ping_p_i    (ping_p),
        .ping_n_i    (ping_n),
        .ack_p_i     (ack_p),
        .ack_n_i     (ack_n),
        .alert_p_o   (alert_p),
        .alert_n_o   (alert_n),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alert_ack === 1'b1) n_alert_ack++;
        if (ping_ok === 1'b1) n_ping_ok++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // From PH1: ack rises, PH2 appears 3 cycles later, ack falls, completion pulse 3 cycles later.
    task automatic do_ack(input string tag);
        ack_p = 1'b1; ack_n = 1'b0;
        tick(2);
        check({tag, "_ph1_hold"}, {alert_p, alert_n}, 2'b10);
        tick();
        check({tag, "_ph2"}, {alert_p, alert_n}, 2'b01);
        ack_p = 1'b0; ack_n = 1'b1;
        tick(2);
        check({tag, "_no_early_pulse"}, {alert_ack, ping_ok}, 2'b00);
        tick();
    endtask

    initial begin
        rst = 1'b1; alert_req = 1'b0;
        ping_p = 1'b0; ping_n = 1'b1; ack_p = 1'b0; ack_n = 1'b1;
        #3;
        check("rst_pair", {alert_p, alert_n}, 2'b01);
        check("rst_pulses", {alert_ack, ping_ok, integ_fail}, 3'b000);
        check("rst_state", state_dbg, 2'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Alert handshake with exact latencies; a request in the completion cycle re-arms.
        alert_req = 1'b1; tick(); alert_req = 1'b0;
        check("t1_ph1", {alert_p, alert_n}, 2'b10);
        tick(4);
        check("t1_ph1_wait", {alert_p, alert_n}, 2'b10);
        ack_p = 1'b1; ack_n = 1'b0;
        tick(2);
        check("t1_sync_delay", {alert_p, alert_n}, 2'b10);
        tick();
        check("t1_ph2", {alert_p, alert_n}, 2'b01);
        tick(2);
        ack_p = 1'b0; ack_n = 1'b1;
        tick(2);
        check("t1_no_early_ack", alert_ack, 1'b0);
        alert_req = 1'b1;
        tick(); alert_req = 1'b0;
        check("t1_ack_pulse", {alert_ack, ping_ok}, 2'b10);
        tick();
        check("t1_ack_single", alert_ack, 1'b0);
        check("t1_pause0", {alert_p, alert_n}, 2'b01);
        tick();
        check("t1_pause_idle", {alert_p, alert_n}, 2'b01);
        tick();
        check("t1_rearm_ph1", {alert_p, alert_n}, 2'b10);
        do_ack("t1b");
        check("t1b_ack_pulse", {alert_ack, ping_ok}, 2'b10);
        tick(3);

        // Ping toggle starts PH1 three cycles later and completes with ping_ok.
        ping_p = 1'b1; ping_n = 1'b0;
        tick();
        check("t2_wait1", {alert_p, alert_n}, 2'b01);
        tick();
        check("t2_wait2", {alert_p, alert_n}, 2'b01);
        tick();
        check("t2_ph1", {alert_p, alert_n}, 2'b10);
        do_ack("t2");
        check("t2_ping_ok", {alert_ack, ping_ok}, 2'b01);
        tick(3);

        // Alert and ping together: one handshake, reported as an alert.
        base = n_ping_ok;
        ping_p = 1'b0; ping_n = 1'b1; alert_req = 1'b1;
        tick(); alert_req = 1'b0;
        check("t3_ph1", {alert_p, alert_n}, 2'b10);
        do_ack("t3");
        check("t3_alert_ack", {alert_ack, ping_ok}, 2'b10);
        tick(8);
        check("t3_stays_idle", {alert_p, alert_n}, 2'b01);
        check("t3_no_ping_ok", n_ping_ok - base, 0);

        // Ack pair forced invalid for 5 cycles during PH1.
        alert_req = 1'b1; tick(); alert_req = 1'b0;
        check("t4_ph1", {alert_p, alert_n}, 2'b10);
        ack_p = 1'b1; ack_n = 1'b1;
        for (int d = 1; d <= 8; d++) begin
            tick();
            check($sformatf("t4_integ_d%0d", d), integ_fail, (d >= 2 && d <= 6) ? 1'b1 : 1'b0);
            check($sformatf("t4_pair_d%0d", d), {alert_p, alert_n},
                  (d >= 3 && d <= 7) ? 2'b11 : 2'b10);
            if (d == 5) begin
                ack_p = 1'b0; ack_n = 1'b1;
            end
        end
        do_ack("t4");
        check("t4_alert_ack", {alert_ack, ping_ok}, 2'b10);
        tick(3);

        // Three requests during PH1 collapse into one extra handshake.
        base = n_alert_ack;
        alert_req = 1'b1; tick(); alert_req = 1'b0;
        check("t5_ph1", {alert_p, alert_n}, 2'b10);
        for (int k = 0; k < 3; k++) begin
            alert_req = 1'b1; tick(); alert_req = 1'b0; tick();
        end
        do_ack("t5a");
        check("t5a_pulse", alert_ack, 1'b1);
        tick(3);
        check("t5_second_ph1", {alert_p, alert_n}, 2'b10);
        do_ack("t5b");
        check("t5b_pulse", alert_ack, 1'b1);
        tick(8);
        check("t5_idle", {alert_p, alert_n}, 2'b01);
        check("t5_total_acks", n_alert_ack - base, 2);

        // Reset during PH1 drops the pair to idle without waiting for a clock.
        alert_req = 1'b1; tick(); alert_req = 1'b0;
        check("t6_ph1", {alert_p, alert_n}, 2'b10);
        #2 rst = 1'b1;
        #1 check("t6_async_pair", {alert_p, alert_n}, 2'b01);
        tick();
        rst = 1'b0;
        tick(2);

        // Reset during PH2: pending handshake is lost, no completion afterwards.
        alert_req = 1'b1; tick(); alert_req = 1'b0;
        ack_p = 1'b1; ack_n = 1'b0;
        tick(3);
        check("t7_ph2", {alert_p, alert_n}, 2'b01);
        check("t7_ph2_state", state_dbg, 2'd2);
        #2 rst = 1'b1;
        #1 check("t7_async_pair", {alert_p, alert_n}, 2'b01);
        check("t7_async_state", state_dbg, 2'd0);
        base = n_alert_ack;
        ack_p = 1'b0; ack_n = 1'b1;
        tick();
        rst = 1'b0;
        tick(8);
        check("t7_no_ack", n_alert_ack - base, 0);
        check("t7_idle", {alert_p, alert_n}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
